// File: rtl/linear_interp_upsampler.sv
// -----------------------------------------------------------------------------
// linear_interp_upsampler
//
// Purpose:
//   Interpolating upsampler placed after the decimating filter chain. Input
//   samples (16-bit signed) arrive at the decimated rate into a small FIFO.
//   For every input sample, 2^L_LOG2 linearly interpolated samples are emitted
//   on an AXI-stream style master port, ramping from the previously emitted
//   sample (prev) toward the new target sample (cur):
//       y_k = floor((prev*L + k*(cur - prev)) / L),  k = 0 .. L-1
//
// Ports:
//   aclk      in   system clock, rising edge
//   aresetn   in   asynchronous active-low reset
//   s_tdata   in   [15:0] signed input sample
//   s_tvalid  in   input sample valid
//   s_tready  out  FIFO not full (decoded from the registered count)
//   m_tdata   out  [15:0] signed interpolated output sample
//   m_tvalid  out  output sample valid
//   m_tready  in   downstream accepts output sample
//   overflow  out  sticky: an input sample was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module linear_interp_upsampler #(
  parameter int L_LOG2          = 3,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;  // count must reach DEPTH
  localparam int AW    = 17 + L_LOG2;          // holds prev*L + k*delta

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]                r_fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_overflow;

  logic        w_push;
  logic        w_pop;
  logic        w_fifo_empty;
  logic [15:0] w_fifo_head;

  // Ready depends only on the registered count, so a pop in the same cycle
  // never opens the FIFO to a write while it is full.
  assign s_tready     = (r_count != CW'(DEPTH));
  assign w_push       = s_tvalid & s_tready;
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_head  = r_fifo_mem[r_rd_ptr];

  // Storage carries no reset: only pointers/count define the FIFO contents.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= s_tdata;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (s_tvalid && !s_tready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign overflow = r_overflow;

  // ---------------------------------------------------------------------------
  // Interpolator datapath registers
  // ---------------------------------------------------------------------------
  logic [15:0]       r_prev;   // last fully emitted sample
  logic [15:0]       r_cur;    // current target sample
  logic [16:0]       r_delta;  // cur - prev, signed
  logic [AW-1:0]     r_acc;    // prev*L + k*delta, signed
  logic [L_LOG2-1:0] r_k;

  logic              w_handshake;
  logic              w_last;
  logic              w_step;
  logic              w_retire;
  logic [15:0]       w_base;
  logic [AW-1:0]     w_base_ext;
  logic [16:0]       w_new_delta;
  logic [AW-1:0]     w_delta_ext;

  assign m_tvalid    = (r_state == ST_RUN);
  assign w_handshake = m_tvalid & m_tready;
  assign w_last      = &r_k;

  // Starting point of a new ramp: from IDLE it is prev (already updated when
  // the last burst retired); when chaining bursts inside RUN it is cur, which
  // becomes prev on that same edge.
  assign w_base      = (r_state == ST_RUN) ? r_cur : r_prev;
  assign w_base_ext  = {{(AW-16){w_base[15]}}, w_base};
  assign w_new_delta = {w_fifo_head[15], w_fifo_head} - {w_base[15], w_base};
  assign w_delta_ext = {{(AW-17){r_delta[16]}}, r_delta};

  // acc >>> L_LOG2 is floor(acc / L); the result always lies between prev and
  // cur, so the low 16 bits of the shifted value are exact.
  assign m_tdata = r_acc[L_LOG2 +: 16];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_step       = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_handshake) begin
          if (!w_last) begin
            w_step = 1'b1;
          end else begin
            w_retire = 1'b1;
            // Chain straight into the next ramp when a sample is waiting so
            // consecutive bursts have no bubble.
            if (!w_fifo_empty) begin
              w_pop = 1'b1;
            end else begin
              w_state_next = ST_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_prev  <= '0;
      r_cur   <= '0;
      r_delta <= '0;
      r_acc   <= '0;
      r_k     <= '0;
    end else begin
      if (w_retire) begin
        r_prev <= r_cur;
      end
      if (w_pop) begin
        r_cur   <= w_fifo_head;
        r_delta <= w_new_delta;
        r_acc   <= w_base_ext << L_LOG2;
        r_k     <= '0;
      end else if (w_step) begin
        r_acc <= r_acc + w_delta_ext;
        r_k   <= r_k + L_LOG2'(1);
      end
    end
  end

endmodule

// File: tb/tb_linear_interp_upsampler.sv
// -----------------------------------------------------------------------------
// tb_linear_interp_upsampler
//
// Self-checking bench: every accepted input sample pushes its L expected
// interpolated outputs (computed from the floor formula) to a scoreboard
// queue; each output handshake pops and compares.
// -----------------------------------------------------------------------------
module tb_linear_interp_upsampler;

  localparam int L_LOG2 = 3;
  localparam int L      = 1 << L_LOG2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        overflow;

  int sb[$];
  int model_prev = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  linear_interp_upsampler #(
    .L_LOG2          (L_LOG2),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .overflow (overflow)
  );

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    sb.delete();
    model_prev = 0;
  endtask

  // Present one sample for one cycle; when the caller expects it to be
  // accepted, queue the L outputs it must produce.
  task automatic push_sample(input int v, input bit expect_accept);
    s_tdata  = 16'(v);
    s_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    if (expect_accept) begin
      for (int k = 0; k < L; k++) begin
        sb.push_back((model_prev * L + k * (v - model_prev)) >>> L_LOG2);
      end
      model_prev = v;
    end
  endtask

  // Wait (bounded) for the next output handshake and return its data and the
  // number of idle cycles seen before it.
  task automatic get_output(input int budget, output int d, output int waited, output bit ok);
    ok = 1'b0;
    waited = 0;
    d = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_tvalid && m_tready) begin
        d  = int'($signed(m_tdata));
        ok = 1'b1;
        @(posedge aclk);
        #1;
        return;
      end
      waited++;
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #12;
    n_vec++;
    if (m_tvalid !== 1'b0 || m_tdata !== 16'd0 || overflow !== 1'b0 || s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got tvalid=%b tdata=%0d ovf=%b ready=%b, want 0 0 0 1",
               m_tvalid, m_tdata, overflow, s_tready);
    end
    do_reset();
    n_vec++;
    if (m_tvalid !== 1'b0 || m_tdata !== 16'd0 || s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got tvalid=%b tdata=%0d ready=%b, want 0 0 1",
               m_tvalid, m_tdata, s_tready);
    end
  endtask

  task automatic test_ramp();
    int d, w, e;
    bit ok;
    m_tready = 1'b1;
    push_sample(800, 1'b1);
    for (int i = 0; i < L; i++) begin
      get_output(20, d, w, ok);
      e = (sb.size() > 0) ? sb.pop_front() : 99999;
      n_vec++;
      if (!ok || d !== e) begin
        n_err++;
        $display("FAIL ramp_up[%0d]: got %0d (ok=%b), want %0d", i, d, ok, e);
      end
    end
    n_vec++;
    if (m_tvalid !== 1'b0 || m_tdata !== 16'd700) begin
      n_err++;
      $display("FAIL ramp_idle: got tvalid=%b tdata=%0d, want 0 700", m_tvalid, $signed(m_tdata));
    end
    push_sample(0, 1'b1);
    for (int i = 0; i < L; i++) begin
      get_output(20, d, w, ok);
      e = (sb.size() > 0) ? sb.pop_front() : 99999;
      n_vec++;
      if (!ok || d !== e) begin
        n_err++;
        $display("FAIL ramp_down[%0d]: got %0d (ok=%b), want %0d", i, d, ok, e);
      end
    end
  endtask

  task automatic test_negative_rounding();
    int d, w, e;
    bit ok;
    m_tready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      push_sample(-3, 1'b1);
      for (int i = 0; i < L; i++) begin
        get_output(20, d, w, ok);
        e = (sb.size() > 0) ? sb.pop_front() : 99999;
        n_vec++;
        if (!ok || d !== e) begin
          n_err++;
          $display("FAIL neg_round[b%0d k%0d]: got %0d (ok=%b), want %0d", b, i, d, ok, e);
        end
      end
    end
  endtask

  task automatic test_full_scale();
    int d, w, e;
    bit ok;
    m_tready = 1'b1;
    push_sample(32767, 1'b1);
    push_sample(-32768, 1'b1);
    for (int i = 0; i < 2 * L; i++) begin
      get_output(20, d, w, ok);
      e = (sb.size() > 0) ? sb.pop_front() : 99999;
      n_vec++;
      if (!ok || d !== e) begin
        n_err++;
        $display("FAIL full_scale[%0d]: got %0d (ok=%b), want %0d", i, d, ok, e);
      end
      if (i == L) begin
        n_vec++;
        if (d !== 32767) begin
          n_err++;
          $display("FAIL full_scale_first: got %0d, want 32767", d);
        end
      end
      if (i == 2 * L - 1) begin
        n_vec++;
        if (d !== -24577) begin
          n_err++;
          $display("FAIL full_scale_k7: got %0d, want -24577", d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int d, w, e, y3, gaps;
    bit ok;
    m_tready = 1'b0;
    push_sample(160, 1'b1);
    push_sample(-400, 1'b1);
    push_sample(1234, 1'b1);
    m_tready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 3; i++) begin
      get_output(20, d, w, ok);
      e = (sb.size() > 0) ? sb.pop_front() : 99999;
      n_vec++;
      if (!ok || d !== e) begin
        n_err++;
        $display("FAIL bp_pre[%0d]: got %0d (ok=%b), want %0d", i, d, ok, e);
      end
    end
    // Stall at k=3 for five cycles.
    m_tready = 1'b0;
    y3 = (sb.size() > 0) ? sb[0] : 99999;
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (m_tvalid !== 1'b1 || int'($signed(m_tdata)) !== y3) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got tvalid=%b tdata=%0d, want 1 %0d",
                 c, m_tvalid, $signed(m_tdata), y3);
      end
      @(posedge aclk);
      #1;
    end
    m_tready = 1'b1;
    for (int i = 3; i < 3 * L; i++) begin
      get_output(20, d, w, ok);
      gaps += w;
      e = (sb.size() > 0) ? sb.pop_front() : 99999;
      n_vec++;
      if (!ok || d !== e) begin
        n_err++;
        $display("FAIL bp_post[%0d]: got %0d (ok=%b), want %0d", i, d, ok, e);
      end
    end
    n_vec++;
    if (gaps !== 0) begin
      n_err++;
      $display("FAIL bp_gapless: got %0d idle cycles between outputs, want 0", gaps);
    end
  endtask

  task automatic test_overflow();
    int d, w, e;
    bit ok;
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (s_tready !== (i < 5)) begin
        n_err++;
        $display("FAIL ovf_ready[%0d]: got %b, want %b", i, s_tready, (i < 5));
      end
      push_sample((i + 1) * 16, i < 5);
    end
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: got %b, want 1", overflow);
    end
    m_tready = 1'b1;
    for (int i = 0; i < 5 * L; i++) begin
      get_output(20, d, w, ok);
      e = (sb.size() > 0) ? sb.pop_front() : 99999;
      n_vec++;
      if (!ok || d !== e) begin
        n_err++;
        $display("FAIL ovf_drain[%0d]: got %0d (ok=%b), want %0d", i, d, ok, e);
      end
    end
    repeat (4) @(posedge aclk);
    #1;
    n_vec++;
    if (overflow !== 1'b1 || m_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_sticky: got ovf=%b tvalid=%b, want 1 0", overflow, m_tvalid);
    end
    do_reset();
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %b, want 0", overflow);
    end
  endtask

  task automatic test_reset_mid_burst();
    int d, w, e, stray;
    bit ok;
    do_reset();
    m_tready = 1'b0;
    push_sample(500, 1'b1);
    push_sample(-500, 1'b1);
    push_sample(250, 1'b1);
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_output(20, d, w, ok);
      e = (sb.size() > 0) ? sb.pop_front() : 99999;
      n_vec++;
      if (!ok || d !== e) begin
        n_err++;
        $display("FAIL rst_pre[%0d]: got %0d (ok=%b), want %0d", i, d, ok, e);
      end
    end
    aresetn = 1'b0;
    #1;
    n_vec++;
    if (m_tvalid !== 1'b0 || m_tdata !== 16'd0 || s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_async: got tvalid=%b tdata=%0d ready=%b, want 0 0 1",
               m_tvalid, $signed(m_tdata), s_tready);
    end
    do_reset();
    m_tready = 1'b1;
    push_sample(80, 1'b1);
    for (int i = 0; i < L; i++) begin
      get_output(20, d, w, ok);
      e = (sb.size() > 0) ? sb.pop_front() : 99999;
      n_vec++;
      if (!ok || d !== e) begin
        n_err++;
        $display("FAIL rst_post[%0d]: got %0d (ok=%b), want %0d", i, d, ok, e);
      end
    end
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_tvalid) stray++;
      @(posedge aclk);
      #1;
    end
    n_vec++;
    if (stray !== 0) begin
      n_err++;
      $display("FAIL rst_discard: got %0d valid cycles after burst, want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative_rounding();
    test_full_scale();
    test_back_to_back();
    test_overflow();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case a task ever stalls outside its bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
